uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  UART receive controller: synchronises RX pin, detects start-bit falling edge, gates the
//  RX baud-pulse generator via Count_Sig, samples 8N1 frames on its mid-bit BPS_CLK pulses.
//  Sits between the pad and the byte consumer (command parser / FIFO); LSB-first data out.
// PARAMETERS
//  DATA_BITS    8   data bits per frame (fixed 8 for this design; width of RX_Data)
//  SYNC_STAGES  2   flops in RX pin synchroniser (>=2)
// PORTS
//  CLK          in   1          system clock, 50 MHz
//  RSTn         in   1          asynchronous, active-low reset
//  RX_En        in   1          1 = accept new frames; 0 = ignore start edges (frame in flight completes)
//  RX_Pin_In    in   1          raw serial line, idle high, asynchronous to CLK
//  BPS_CLK      in   1          1-cycle mid-bit sample strobe from baud-pulse generator
//  Count_Sig    out  1          1 = baud counter enabled; 0 = counter held at 0
//  RX_Data      out  DATA_BITS  last received byte, held until next frame completes
//  RX_Done_Sig  out  1          1-cycle pulse: RX_Data valid, stop bit was 1
//  Frame_Err    out  1          1-cycle pulse: stop bit sampled 0 (RX_Data still updated)
// BEHAVIOUR
//  Reset: all sync flops 1 (line idle), state IDLE, Count_Sig=0, RX_Data=0, RX_Done_Sig=0,
//   Frame_Err=0, bit counter 0, shift register 0. Reset mid-frame aborts; no partial outputs.
//  Edge detect: falling edge = previous synced sample 1 AND current synced sample 0.
//   Pin low -> edge flag high after SYNC_STAGES+1 cycles.
//  Baud contract: BPS_CLK first fires mid-start-bit after Count_Sig rises, then once per bit
//   period at mid-bit while Count_Sig stays 1; Count_Sig=0 restarts phase.
//  FSM (one-hot or binary, encodings in package):
//   IDLE : Count_Sig=0. Edge AND RX_En -> START, Count_Sig=1 next cycle.
//          Edge with RX_En=0 ignored.
//   START: wait BPS_CLK; sample synced RX. 0 -> DATA, bit_cnt=0. 1 -> false start: IDLE,
//          Count_Sig=0 next cycle, no output pulses.
//   DATA : on each BPS_CLK shift sample into bit[bit_cnt] (LSB first), bit_cnt+1;
//          after bit_cnt==DATA_BITS-1 sampled -> STOP.
//   STOP : on BPS_CLK: load RX_Data<=shift reg; sample 1 -> RX_Done_Sig=1 for one cycle;
//          sample 0 -> Frame_Err=1 for one cycle. Either -> IDLE, Count_Sig=0 same edge.
//  Latency: RX_Done_Sig/Frame_Err and new RX_Data appear the cycle after stop-bit BPS_CLK.
//  Back-to-back: returning to IDLE at mid-stop leaves line high; next start edge accepted
//   with no dead time. Edges during START/DATA/STOP are ignored (no re-arm).
//  RX_Done_Sig and Frame_Err never high together. BPS_CLK in IDLE ignored.
//  bit_cnt width clog2(DATA_BITS); never wraps (FSM leaves DATA at DATA_BITS-1).
//  RX_Data only changes on frame completion; stable otherwise.
// STRUCTURE
//  Package uart_rx_pkg: state encoding constants (IDLE/START/DATA/STOP), DATA_BITS default.
//  Sub-module rx_edge_detect: SYNC_STAGES synchroniser + falling-edge pulse; outputs
//   synced level and 1-cycle H2L pulse. Top holds FSM, bit counter, shift reg, outputs.
// TESTING (bench pairs DUT with baud generator, 50 MHz, 9600 baud = 5208 clk/bit)
//  1 Send 0x55, stop=1 -> RX_Data=0x55, RX_Done_Sig one cycle, Frame_Err=0, Count_Sig
//    high from ~start edge to mid-stop then 0.
//  2 Low glitch 1000 cycles then high -> START sees 1 at mid-bit; no pulses, Count_Sig=0,
//    RX_Data unchanged; following frame 0xA3 received correctly.
//  3 Send 0xA3 with stop=0 -> Frame_Err one cycle, RX_Done_Sig=0, RX_Data=0xA3.
//  4 Back-to-back 0x00,0xFF,0x81 with no idle gap -> three Done pulses, data in order.
//  5 Assert RSTn=0 mid-DATA bit 4, release, send 0x3C -> all outputs 0 during reset;
//    0x3C received, no spurious pulse.
//  6 RX_En=0, send 0x12 -> Count_Sig stays 0, no pulses; RX_En=1, send 0x34 -> 0x34 Done.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive controller: state encodings and default widths.
package uart_rx_pkg;

    localparam int unsigned DATA_BITS_DEF   = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/rx_edge_detect.sv
// RX pin synchroniser (idle-high) with a registered one-cycle high-to-low edge pulse.
module rx_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic rx_i,
    output logic rx_sync_o,
    output logic h2l_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   h2l_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            h2l_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            // Registered so the edge flag rises SYNC_STAGES+1 cycles after the pin falls.
            h2l_q  <= prev_q & ~sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_sync_o = sync_q[SYNC_STAGES-1];
    assign h2l_o     = h2l_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive controller: gates the baud-pulse generator and samples frames on BPS_CLK.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS   = DATA_BITS_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 RX_En,
    input  logic                 RX_Pin_In,
    input  logic                 BPS_CLK,
    output logic                 Count_Sig,
    output logic [DATA_BITS-1:0] RX_Data,
    output logic                 RX_Done_Sig,
    output logic                 Frame_Err
);

    localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    logic rx_sync;
    logic h2l;

    rx_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .rx_i      (RX_Pin_In),
        .rx_sync_o (rx_sync),
        .h2l_o     (h2l)
    );

    logic [1:0]           state_q,   state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 count_q,   count_d;
    logic                 done_q,    done_d;
    logic                 ferr_q,    ferr_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (h2l && RX_En) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (BPS_CLK) begin
                    if (!rx_sync) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (BPS_CLK) begin
                    shift_d[bit_cnt_q] = rx_sync;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (BPS_CLK) begin
                    data_d  = shift_q;
                    done_d  = rx_sync;
                    ferr_d  = ~rx_sync;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Baud counter runs exactly while the FSM is out of IDLE, from the following cycle.
        count_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            count_q   <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            count_q   <= count_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign Count_Sig   = count_q;
    assign RX_Data     = data_q;
    assign RX_Done_Sig = done_q;
    assign Frame_Err   = ferr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl with a behavioural baud-pulse generator (shortened bit period).
module tb_uart_rx_ctrl;

    localparam int unsigned BIT  = 16;
    localparam int unsigned HALF = BIT / 2;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       RX_En = 1'b1;
    logic       RX_Pin_In = 1'b1;
    logic       BPS_CLK;
    logic       Count_Sig;
    logic [7:0] RX_Data;
    logic       RX_Done_Sig;
    logic       Frame_Err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ferr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_data = 8'h00;

    always #10 CLK = ~CLK;

    uart_rx_ctrl #(
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .RX_En       (RX_En),
        .RX_Pin_In   (RX_Pin_In),
        .BPS_CLK     (BPS_CLK),
        .Count_Sig   (Count_Sig),
        .RX_Data     (RX_Data),
        .RX_Done_Sig (RX_Done_Sig),
        .Frame_Err   (Frame_Err)
    );

    // Baud generator: held at 0 while Count_Sig=0, strobes at mid-bit.
    int unsigned bcnt;
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn)                bcnt <= 0;
        else if (!Count_Sig)      bcnt <= 0;
        else if (bcnt == BIT - 1) bcnt <= 0;
        else                      bcnt <= bcnt + 1;
    end
    assign BPS_CLK = Count_Sig && (bcnt == HALF);

    task automatic fail_msg(input string name, input int unsigned act, input int unsigned req);
        errors++;
        if (errors <= 20)
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    endtask

    // Monitor: pops the scoreboard on each output pulse; otherwise RX_Data must hold.
    always @(negedge CLK) begin
        exp_t e;
        if (!RSTn) begin
            exp_data = 8'h00;
        end else if (RX_Done_Sig || Frame_Err) begin
            checks++;
            if (RX_Done_Sig && Frame_Err) fail_msg("done_and_ferr", 1, 0);
            checks++;
            if (sb.size() == 0) begin
                fail_msg("unexpected_pulse", {RX_Done_Sig, Frame_Err}, 0);
            end else begin
                e = sb.pop_front();
                if (Frame_Err !== e.ferr) fail_msg("pulse_kind_ferr", Frame_Err, e.ferr);
                if (RX_Data !== e.data)   fail_msg("rx_data", RX_Data, e.data);
                exp_data = e.data;
            end
        end else begin
            checks++;
            if (RX_Data !== exp_data) fail_msg("rx_data_hold", RX_Data, exp_data);
        end
    end

    task automatic hold(input int unsigned n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) fail_msg(name, act, req);
    endtask

    // One 8N1 frame; Count_Sig checked mid data bit 4 against exp_busy.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic exp_busy,
                              input logic push);
        if (push) sb.push_back('{ferr: ~stop, data: d});
        RX_Pin_In = 1'b0;
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            RX_Pin_In = d[i];
            if (i == 4) begin
                hold(HALF);
                check("count_sig_mid_frame", Count_Sig, exp_busy);
                hold(BIT - HALF);
            end else begin
                hold(BIT);
            end
        end
        RX_Pin_In = stop;
        hold(BIT);
    endtask

    logic [7:0] partial;

    initial begin
        hold(3);
        check("reset_count_sig", Count_Sig, 0);
        check("reset_rx_data", RX_Data, 0);
        check("reset_done", RX_Done_Sig, 0);
        check("reset_ferr", Frame_Err, 0);
        RSTn = 1'b1;
        hold(10);

        // 1: good frame 0x55
        send_frame(8'h55, 1'b1, 1'b1, 1'b1);
        RX_Pin_In = 1'b1;
        hold(4);
        check("count_sig_after_stop", Count_Sig, 0);
        hold(20);

        // 2: short low glitch -> false start, then 0xA3
        RX_Pin_In = 1'b0;
        hold(4);
        RX_Pin_In = 1'b1;
        hold(6);
        check("count_sig_false_start_armed", Count_Sig, 1);
        hold(30);
        check("count_sig_after_false_start", Count_Sig, 0);
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1);
        RX_Pin_In = 1'b1;
        hold(20);

        // 3: framing error
        send_frame(8'hA3, 1'b0, 1'b1, 1'b1);
        RX_Pin_In = 1'b1;
        hold(20);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
        RX_Pin_In = 1'b1;
        hold(20);

        // 4: back-to-back, no idle gap
        send_frame(8'h00, 1'b1, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b1);
        send_frame(8'h81, 1'b1, 1'b1, 1'b1);
        RX_Pin_In = 1'b1;
        hold(20);

        // 5: reset during data bit 4
        partial = 8'h6B;
        RX_Pin_In = 1'b0;
        hold(BIT);
        for (int i = 0; i < 4; i++) begin
            RX_Pin_In = partial[i];
            hold(BIT);
        end
        RX_Pin_In = partial[4];
        hold(HALF);
        RSTn = 1'b0;
        #1;
        check("midreset_count_sig", Count_Sig, 0);
        check("midreset_rx_data", RX_Data, 0);
        check("midreset_done", RX_Done_Sig, 0);
        check("midreset_ferr", Frame_Err, 0);
        hold(4);
        RX_Pin_In = 1'b1;
        hold(2);
        RSTn = 1'b1;
        hold(10);
        check("after_reset_count_sig", Count_Sig, 0);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        RX_Pin_In = 1'b1;
        hold(20);

        // 6: RX_En gating
        RX_En = 1'b0;
        hold(2);
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        RX_Pin_In = 1'b1;
        hold(10);
        check("disabled_count_sig", Count_Sig, 0);
        RX_En = 1'b1;
        hold(4);
        send_frame(8'h34, 1'b1, 1'b1, 1'b1);
        RX_Pin_In = 1'b1;
        hold(20);

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
